// File: rtl/traffic_gen_pkg.sv
// Shared definitions for the AXI-Stream traffic generator: register map,
// control bit positions, FSM encoding and the byte pattern helper.
package traffic_gen_pkg;

  localparam logic [29:0] REG_CTRL   = 30'd0;
  localparam logic [29:0] REG_LEN    = 30'd1;
  localparam logic [29:0] REG_COUNT  = 30'd2;
  localparam logic [29:0] REG_DEST   = 30'd3;
  localparam logic [29:0] REG_GAP    = 30'd4;
  localparam logic [29:0] REG_SENT   = 30'd5;
  localparam logic [29:0] REG_STATUS = 30'd6;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_STOP_BIT   = 1;
  localparam int unsigned STATUS_BUSY_BIT = 0;

  localparam logic [1:0] AXIL_RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10
  } tg_state_e;

  // Byte idx of a beat whose first byte is base; wraps naturally at 256.
  function automatic logic [7:0] pattern_byte(input logic [7:0] base, input int unsigned idx);
    logic [31:0] idx_v;
    idx_v = idx;
    return base + idx_v[7:0];
  endfunction

endpackage

// File: rtl/axil_reg_slave.sv
// Minimal AXI-Lite slave front end: turns bus handshakes into single-cycle
// write/read strobes with a word address, for use by any register block.
module axil_reg_slave
  import traffic_gen_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] ctrl_awaddr,
  input  logic        ctrl_awvalid,
  output logic        ctrl_awready,
  input  logic [31:0] ctrl_wdata,
  input  logic        ctrl_wvalid,
  output logic        ctrl_wready,
  output logic [1:0]  ctrl_bresp,
  output logic        ctrl_bvalid,
  input  logic        ctrl_bready,
  input  logic [31:0] ctrl_araddr,
  input  logic        ctrl_arvalid,
  output logic        ctrl_arready,
  output logic [31:0] ctrl_rdata,
  output logic [1:0]  ctrl_rresp,
  output logic        ctrl_rvalid,
  input  logic        ctrl_rready,
  output logic        wr_en,
  output logic [29:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        rd_en,
  output logic [29:0] rd_addr,
  input  logic [31:0] rd_data
);

  logic        aw_w_ready_r;
  logic        bvalid_r;
  logic [1:0]  bresp_r;
  logic [29:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic        arready_r;
  logic        rvalid_r;
  logic [1:0]  rresp_r;
  logic [31:0] rdata_r;
  logic [29:0] rd_addr_r;
  logic        unused_addr_s;

  assign unused_addr_s = &{1'b0, ctrl_awaddr[1:0], ctrl_araddr[1:0]};

  // Write channel: accept only with address and data together, then respond.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_w_ready_r <= 1'b0;
      bvalid_r     <= 1'b0;
      bresp_r      <= 2'b00;
      wr_addr_r    <= 30'd0;
      wr_data_r    <= 32'd0;
    end else if (aw_w_ready_r) begin
      aw_w_ready_r <= 1'b0;
      bvalid_r     <= 1'b1;
      bresp_r      <= AXIL_RESP_OKAY;
    end else if (bvalid_r && ctrl_bready) begin
      bvalid_r <= 1'b0;
    end else if (ctrl_awvalid && ctrl_wvalid && !bvalid_r) begin
      aw_w_ready_r <= 1'b1;
      wr_addr_r    <= ctrl_awaddr[31:2];
      wr_data_r    <= ctrl_wdata;
    end
  end

  // Read channel: rdata is captured once and held until the master takes it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= 32'd0;
      rd_addr_r <= 30'd0;
    end else if (arready_r) begin
      arready_r <= 1'b0;
      rvalid_r  <= 1'b1;
      rresp_r   <= AXIL_RESP_OKAY;
      rdata_r   <= rd_data;
    end else if (rvalid_r && ctrl_rready) begin
      rvalid_r <= 1'b0;
    end else if (ctrl_arvalid && !rvalid_r) begin
      arready_r <= 1'b1;
      rd_addr_r <= ctrl_araddr[31:2];
    end
  end

  assign ctrl_awready = aw_w_ready_r;
  assign ctrl_wready  = aw_w_ready_r;
  assign ctrl_bvalid  = bvalid_r;
  assign ctrl_bresp   = bresp_r;
  assign ctrl_arready = arready_r;
  assign ctrl_rvalid  = rvalid_r;
  assign ctrl_rresp   = rresp_r;
  assign ctrl_rdata   = rdata_r;
  assign wr_en        = aw_w_ready_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign rd_en        = arready_r;
  assign rd_addr      = rd_addr_r;

endmodule

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet generator with an AXI-Lite control block: emits COUNT
// packets of LEN bytes carrying an incrementing byte pattern, GAP cycles apart.
module axis_traffic_gen
  import traffic_gen_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  output logic [AXIS_BUS_WIDTH-1:0]    axis_out_tdata,
  output logic [AXIS_DEST_WIDTH-1:0]   axis_out_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]  axis_out_tkeep,
  output logic                         axis_out_tlast,
  output logic                         axis_out_tvalid,
  input  logic                         axis_out_tready,
  input  logic [31:0]                  ctrl_awaddr,
  input  logic                         ctrl_awvalid,
  output logic                         ctrl_awready,
  input  logic [31:0]                  ctrl_wdata,
  input  logic                         ctrl_wvalid,
  output logic                         ctrl_wready,
  output logic [1:0]                   ctrl_bresp,
  output logic                         ctrl_bvalid,
  input  logic                         ctrl_bready,
  input  logic [31:0]                  ctrl_araddr,
  input  logic                         ctrl_arvalid,
  output logic                         ctrl_arready,
  output logic [31:0]                  ctrl_rdata,
  output logic [1:0]                   ctrl_rresp,
  output logic                         ctrl_rvalid,
  input  logic                         ctrl_rready
);

  localparam int unsigned         BYTES      = AXIS_BUS_WIDTH / 8;
  localparam logic [7:0]          BYTES8     = 8'(BYTES);
  localparam logic [LEN_WIDTH:0]  BYTES_W    = (LEN_WIDTH+1)'(BYTES);
  localparam logic [LEN_WIDTH:0]  BYTES_M1_W = (LEN_WIDTH+1)'(BYTES - 1);
  localparam logic [LEN_WIDTH:0]  ONE_W      = (LEN_WIDTH+1)'(1);

  logic        wr_en_s;
  logic [29:0] wr_addr_s;
  logic [31:0] wr_data_s;
  logic        rd_en_s;
  logic [29:0] rd_addr_s;
  logic [31:0] rd_data_s;
  logic        start_s;
  logic        stop_s;
  logic        busy_s;

  logic [LEN_WIDTH-1:0]       len_r;
  logic [31:0]                count_r;
  logic [AXIS_DEST_WIDTH-1:0] dest_r;
  logic [31:0]                gap_r;

  tg_state_e                  state_r;
  logic [AXIS_BUS_WIDTH-1:0]  tdata_r;
  logic [BYTES-1:0]           tkeep_r;
  logic [AXIS_DEST_WIDTH-1:0] tdest_r;
  logic                       tlast_r;
  logic                       tvalid_r;
  logic [31:0]                sent_r;
  logic                       stop_pend_r;
  logic [LEN_WIDTH:0]         beat_r;
  logic [7:0]                 base_r;
  logic [LEN_WIDTH:0]         last_beat_r;
  logic [BYTES-1:0]           last_keep_r;
  logic [31:0]                count_w_r;
  logic [31:0]                gap_w_r;
  logic [31:0]                gap_cnt_r;

  logic [LEN_WIDTH:0] len_eff_s;
  logic [LEN_WIDTH:0] beats_s;
  logic [LEN_WIDTH:0] last_beat_s;
  logic [LEN_WIDTH:0] rem_s;
  logic [BYTES-1:0]   last_keep_s;
  logic [LEN_WIDTH:0] beat_nxt_s;
  logic [7:0]         base_nxt_s;
  logic               stop_now_s;
  logic               done_s;

  function automatic logic [AXIS_BUS_WIDTH-1:0] build_beat(input logic [7:0] base);
    logic [AXIS_BUS_WIDTH-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      d[8*i +: 8] = pattern_byte(base, i);
    end
    return d;
  endfunction

  axil_reg_slave u_axil (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .ctrl_awaddr  (ctrl_awaddr),
    .ctrl_awvalid (ctrl_awvalid),
    .ctrl_awready (ctrl_awready),
    .ctrl_wdata   (ctrl_wdata),
    .ctrl_wvalid  (ctrl_wvalid),
    .ctrl_wready  (ctrl_wready),
    .ctrl_bresp   (ctrl_bresp),
    .ctrl_bvalid  (ctrl_bvalid),
    .ctrl_bready  (ctrl_bready),
    .ctrl_araddr  (ctrl_araddr),
    .ctrl_arvalid (ctrl_arvalid),
    .ctrl_arready (ctrl_arready),
    .ctrl_rdata   (ctrl_rdata),
    .ctrl_rresp   (ctrl_rresp),
    .ctrl_rvalid  (ctrl_rvalid),
    .ctrl_rready  (ctrl_rready),
    .wr_en        (wr_en_s),
    .wr_addr      (wr_addr_s),
    .wr_data      (wr_data_s),
    .rd_en        (rd_en_s),
    .rd_addr      (rd_addr_s),
    .rd_data      (rd_data_s)
  );

  assign start_s    = wr_en_s && (wr_addr_s == REG_CTRL) && wr_data_s[CTRL_START_BIT];
  assign stop_s     = wr_en_s && (wr_addr_s == REG_CTRL) && wr_data_s[CTRL_STOP_BIT];
  assign busy_s     = (state_r != ST_IDLE);
  assign stop_now_s = stop_pend_r || stop_s;
  assign done_s     = (count_w_r != 32'd0) && ((sent_r + 32'd1) == count_w_r);

  // Packet geometry from the live LEN register, latched at START.
  always_comb begin
    len_eff_s   = (len_r == '0) ? ONE_W : {1'b0, len_r};
    beats_s     = (len_eff_s + BYTES_M1_W) / BYTES_W;
    last_beat_s = beats_s - ONE_W;
    rem_s       = len_eff_s % BYTES_W;
    last_keep_s = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      last_keep_s[i] = (rem_s == '0) || ((LEN_WIDTH+1)'(i) < rem_s);
    end
    beat_nxt_s = beat_r + ONE_W;
    base_nxt_s = base_r + BYTES8;
  end

  // Register read mux; the slave captures it during its read strobe.
  always_comb begin
    rd_data_s = 32'd0;
    if (rd_en_s) begin
      case (rd_addr_s)
        REG_LEN:    rd_data_s[LEN_WIDTH-1:0] = len_r;
        REG_COUNT:  rd_data_s = count_r;
        REG_DEST:   rd_data_s[AXIS_DEST_WIDTH-1:0] = dest_r;
        REG_GAP:    rd_data_s = gap_r;
        REG_SENT:   rd_data_s = sent_r;
        REG_STATUS: rd_data_s[STATUS_BUSY_BIT] = busy_s;
        default:    rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Configuration registers; the FSM only samples them at START.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_r   <= LEN_WIDTH'(32'd64);
      count_r <= 32'd1;
      dest_r  <= '0;
      gap_r   <= 32'd0;
    end else if (wr_en_s) begin
      case (wr_addr_s)
        REG_LEN:   len_r   <= wr_data_s[LEN_WIDTH-1:0];
        REG_COUNT: count_r <= wr_data_s;
        REG_DEST:  dest_r  <= wr_data_s[AXIS_DEST_WIDTH-1:0];
        REG_GAP:   gap_r   <= wr_data_s;
        default:   ;
      endcase
    end
  end

  // Packet FSM and registered stream outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      tvalid_r    <= 1'b0;
      tlast_r     <= 1'b0;
      tdata_r     <= '0;
      tkeep_r     <= '0;
      tdest_r     <= '0;
      sent_r      <= 32'd0;
      stop_pend_r <= 1'b0;
      beat_r      <= '0;
      base_r      <= 8'd0;
      last_beat_r <= '0;
      last_keep_r <= '0;
      count_w_r   <= 32'd0;
      gap_w_r     <= 32'd0;
      gap_cnt_r   <= 32'd0;
    end else begin
      if (stop_s && busy_s) begin
        stop_pend_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          if (start_s && !stop_s) begin
            state_r     <= ST_SEND;
            sent_r      <= 32'd0;
            count_w_r   <= count_r;
            gap_w_r     <= gap_r;
            tdest_r     <= dest_r;
            last_beat_r <= last_beat_s;
            last_keep_r <= last_keep_s;
            beat_r      <= '0;
            base_r      <= 8'd0;
            tvalid_r    <= 1'b1;
            tdata_r     <= build_beat(8'd0);
            tlast_r     <= (last_beat_s == '0);
            tkeep_r     <= (last_beat_s == '0) ? last_keep_s : '1;
          end
        end
        ST_SEND: begin
          if (axis_out_tready) begin
            if (tlast_r) begin
              sent_r <= sent_r + 32'd1;
              if (done_s || stop_now_s) begin
                state_r     <= ST_IDLE;
                tvalid_r    <= 1'b0;
                tlast_r     <= 1'b0;
                stop_pend_r <= 1'b0;
              end else if (gap_w_r != 32'd0) begin
                state_r   <= ST_GAP;
                tvalid_r  <= 1'b0;
                tlast_r   <= 1'b0;
                gap_cnt_r <= gap_w_r;
              end else begin
                beat_r  <= '0;
                base_r  <= 8'd0;
                tdata_r <= build_beat(8'd0);
                tlast_r <= (last_beat_r == '0);
                tkeep_r <= (last_beat_r == '0) ? last_keep_r : '1;
              end
            end else begin
              beat_r  <= beat_nxt_s;
              base_r  <= base_nxt_s;
              tdata_r <= build_beat(base_nxt_s);
              tlast_r <= (beat_nxt_s == last_beat_r);
              tkeep_r <= (beat_nxt_s == last_beat_r) ? last_keep_r : '1;
            end
          end
        end
        ST_GAP: begin
          // Counts down from GAP so tvalid is low for exactly GAP cycles.
          if (gap_cnt_r <= 32'd1) begin
            if (stop_now_s) begin
              state_r     <= ST_IDLE;
              stop_pend_r <= 1'b0;
            end else begin
              state_r  <= ST_SEND;
              beat_r   <= '0;
              base_r   <= 8'd0;
              tvalid_r <= 1'b1;
              tdata_r  <= build_beat(8'd0);
              tlast_r  <= (last_beat_r == '0);
              tkeep_r  <= (last_beat_r == '0) ? last_keep_r : '1;
            end
          end else begin
            gap_cnt_r <= gap_cnt_r - 32'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
        end
      endcase
    end
  end

  assign axis_out_tdata  = tdata_r;
  assign axis_out_tkeep  = tkeep_r;
  assign axis_out_tdest  = tdest_r;
  assign axis_out_tlast  = tlast_r;
  assign axis_out_tvalid = tvalid_r;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: register-map vector table plus
// hand-written stream sequences checked against an independent pattern model.
module tb_axis_traffic_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] axis_out_tdata;
  logic [3:0]  axis_out_tdest;
  logic [7:0]  axis_out_tkeep;
  logic        axis_out_tlast, axis_out_tvalid, axis_out_tready;
  logic [31:0] ctrl_awaddr, ctrl_wdata, ctrl_araddr, ctrl_rdata;
  logic        ctrl_awvalid, ctrl_awready, ctrl_wvalid, ctrl_wready;
  logic [1:0]  ctrl_bresp, ctrl_rresp;
  logic        ctrl_bvalid, ctrl_bready, ctrl_arvalid, ctrl_arready, ctrl_rvalid, ctrl_rready;

  axis_traffic_gen dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_out_tdata(axis_out_tdata), .axis_out_tdest(axis_out_tdest),
    .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .ctrl_awaddr(ctrl_awaddr), .ctrl_awvalid(ctrl_awvalid), .ctrl_awready(ctrl_awready),
    .ctrl_wdata(ctrl_wdata), .ctrl_wvalid(ctrl_wvalid), .ctrl_wready(ctrl_wready),
    .ctrl_bresp(ctrl_bresp), .ctrl_bvalid(ctrl_bvalid), .ctrl_bready(ctrl_bready),
    .ctrl_araddr(ctrl_araddr), .ctrl_arvalid(ctrl_arvalid), .ctrl_arready(ctrl_arready),
    .ctrl_rdata(ctrl_rdata), .ctrl_rresp(ctrl_rresp), .ctrl_rvalid(ctrl_rvalid),
    .ctrl_rready(ctrl_rready)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  dst;
    int          cyc;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } reg_vec_t;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  logic  rand_ready = 1'b0;
  beat_t cap[$];
  logic  stall_prev = 1'b0;
  logic [76:0] prev_beat;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge aclk) cyc++;

  always @(posedge aclk) begin
    #1;
    if (rand_ready) axis_out_tready = ($urandom_range(0, 1) == 1);
    else            axis_out_tready = 1'b1;
  end

  // Stream monitor: captures handshaken beats and checks hold during stalls.
  always @(negedge aclk) begin
    if (aresetn && stall_prev)
      check("stall_hold", {axis_out_tvalid, axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tdest},
            {1'b1, prev_beat});
    if (aresetn && axis_out_tvalid && axis_out_tready)
      cap.push_back('{d: axis_out_tdata, k: axis_out_tkeep, l: axis_out_tlast, dst: axis_out_tdest, cyc: cyc});
    stall_prev = aresetn && axis_out_tvalid && !axis_out_tready;
    prev_beat  = {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tdest};
  end

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge aclk);
    ctrl_awaddr = a; ctrl_wdata = d; ctrl_awvalid = 1'b1; ctrl_wvalid = 1'b1;
    n = 0;
    while (!(ctrl_awready && ctrl_wready) && n < 16) begin @(negedge aclk); n++; end
    check("aw_w_ready", {ctrl_awready, ctrl_wready}, 2'b11);
    @(negedge aclk);
    ctrl_awvalid = 1'b0; ctrl_wvalid = 1'b0;
    check("bvalid_resp", {ctrl_bvalid, ctrl_awready, ctrl_bresp}, 4'b1000);
    ctrl_bready = 1'b1;
    @(negedge aclk);
    ctrl_bready = 1'b0;
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    @(negedge aclk);
    ctrl_araddr = a; ctrl_arvalid = 1'b1;
    n = 0;
    while (!ctrl_arready && n < 16) begin @(negedge aclk); n++; end
    check("arready", ctrl_arready, 1'b1);
    @(negedge aclk);
    ctrl_arvalid = 1'b0;
    check("rvalid_resp", {ctrl_rvalid, ctrl_rresp}, 3'b100);
    d = ctrl_rdata;
    @(negedge aclk);
    check("rdata_hold", {ctrl_rvalid, ctrl_rdata}, {1'b1, d});
    ctrl_rready = 1'b1;
    @(negedge aclk);
    ctrl_rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    check(name, d, exp);
  endtask

  task automatic configure(input int len, input int count, input int dest, input int gap);
    axil_write(32'h04, len);
    axil_write(32'h08, count);
    axil_write(32'h0C, dest);
    axil_write(32'h10, gap);
    cap.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin @(negedge aclk); k++; end
    check("wait_beats", cap.size(), n);
  endtask

  // Independent model of the byte pattern, keep and tlast per packet.
  task automatic verify_stream(input int npkt, input int len, input logic [3:0] dest);
    int leff, nb, rem, b;
    logic [63:0] d;
    logic [7:0]  k;
    logic [7:0]  ff;
    ff   = 8'hFF;
    leff = (len == 0) ? 1 : len;
    nb   = (leff + 7) / 8;
    rem  = leff % 8;
    check("beat_count", cap.size(), npkt * nb);
    for (int i = 0; i < cap.size() && i < npkt * nb; i++) begin
      b = i % nb;
      for (int j = 0; j < 8; j++) d[8*j +: 8] = 8'((b * 8 + j) % 256);
      k = (b == nb - 1 && rem != 0) ? (ff >> (8 - rem)) : ff;
      check("beat", {cap[i].d, cap[i].k, cap[i].l, cap[i].dst}, {d, k, (b == nb - 1), dest});
    end
  endtask

  reg_vec_t vecs[18];
  logic [31:0] rd;
  int gaps;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; axis_out_tready = 1'b1;
    ctrl_awaddr = 32'd0; ctrl_awvalid = 1'b0; ctrl_wdata = 32'd0; ctrl_wvalid = 1'b0;
    ctrl_bready = 1'b0; ctrl_araddr = 32'd0; ctrl_arvalid = 1'b0; ctrl_rready = 1'b0;
    repeat (4) @(negedge aclk);
    check("rst_stream", {axis_out_tvalid, axis_out_tlast, axis_out_tdata, axis_out_tkeep, axis_out_tdest}, 78'd0);
    check("rst_axil", {ctrl_awready, ctrl_wready, ctrl_bvalid, ctrl_arready, ctrl_rvalid,
                       ctrl_bresp, ctrl_rresp, ctrl_rdata}, 41'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    vecs[0]  = '{1'b0, 32'h04, 32'd0, 32'd64};
    vecs[1]  = '{1'b0, 32'h08, 32'd0, 32'd1};
    vecs[2]  = '{1'b0, 32'h0C, 32'd0, 32'd0};
    vecs[3]  = '{1'b0, 32'h10, 32'd0, 32'd0};
    vecs[4]  = '{1'b0, 32'h14, 32'd0, 32'd0};
    vecs[5]  = '{1'b0, 32'h18, 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 32'h1C, 32'd0, 32'd0};
    vecs[7]  = '{1'b0, 32'h00, 32'd0, 32'd0};
    vecs[8]  = '{1'b1, 32'h04, 32'h0001_1234, 32'd0};
    vecs[9]  = '{1'b0, 32'h04, 32'd0, 32'h0000_1234};
    vecs[10] = '{1'b1, 32'h0F, 32'h0000_00FF, 32'd0};
    vecs[11] = '{1'b0, 32'h0C, 32'd0, 32'h0000_000F};
    vecs[12] = '{1'b1, 32'h40, 32'hDEAD_BEEF, 32'd0};
    vecs[13] = '{1'b0, 32'h40, 32'd0, 32'd0};
    vecs[14] = '{1'b1, 32'h14, 32'h0000_0055, 32'd0};
    vecs[15] = '{1'b0, 32'h14, 32'd0, 32'd0};
    vecs[16] = '{1'b1, 32'h10, 32'd7, 32'd0};
    vecs[17] = '{1'b0, 32'h12, 32'd0, 32'd7};
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) axil_write(vecs[i].addr, vecs[i].data);
      else            read_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Three 8-beat packets back to back.
    configure(64, 3, 5, 0);
    axil_write(32'h00, 32'd1);
    wait_beats(24, 200);
    repeat (5) @(negedge aclk);
    verify_stream(3, 64, 4'd5);
    gaps = 0;
    for (int i = 1; i < cap.size(); i++) if (cap[i].cyc - cap[i-1].cyc != 1) gaps++;
    check("b2b", gaps, 0);
    read_check("sent3", 32'h14, 32'd3);
    read_check("idle3", 32'h18, 32'd0);

    // Short packet with a partial last beat.
    configure(13, 1, 2, 0);
    axil_write(32'h00, 32'd1);
    wait_beats(2, 100);
    repeat (5) @(negedge aclk);
    verify_stream(1, 13, 4'd2);
    if (cap.size() == 2) check("keep13", cap[1].k, 8'h1F);

    // Inter-packet gap of five idle cycles.
    configure(16, 2, 0, 5);
    axil_write(32'h00, 32'd1);
    wait_beats(4, 100);
    repeat (5) @(negedge aclk);
    verify_stream(2, 16, 4'd0);
    if (cap.size() == 4) check("gap5", cap[2].cyc - cap[1].cyc, 6);

    // Random back-pressure.
    configure(40, 3, 1, 0);
    rand_ready = 1'b1;
    axil_write(32'h00, 32'd1);
    wait_beats(15, 600);
    rand_ready = 1'b0;
    repeat (5) @(negedge aclk);
    verify_stream(3, 40, 4'd1);

    // Continuous mode stopped during the third packet.
    configure(64, 0, 3, 0);
    axil_write(32'h00, 32'd1);
    wait_beats(17, 200);
    axil_write(32'h00, 32'd2);
    wait_beats(24, 200);
    repeat (10) @(negedge aclk);
    verify_stream(3, 64, 4'd3);
    read_check("sent_stop", 32'h14, 32'd3);
    read_check("idle_stop", 32'h18, 32'd0);

    // START and STOP together: nothing is sent.
    cap.delete();
    axil_write(32'h00, 32'd3);
    repeat (20) @(negedge aclk);
    check("start_stop", cap.size(), 0);
    read_check("idle_ss", 32'h18, 32'd0);

    // START while busy is ignored.
    configure(64, 2, 0, 0);
    axil_write(32'h00, 32'd1);
    wait_beats(4, 100);
    read_check("busy", 32'h18, 32'd1);
    axil_write(32'h00, 32'd1);
    wait_beats(16, 200);
    repeat (20) @(negedge aclk);
    verify_stream(2, 64, 4'd0);
    read_check("sent_busy", 32'h14, 32'd2);

    // Reset while beat 2 of the first packet is on the bus.
    configure(32, 2, 9, 3);
    axil_write(32'h00, 32'd1);
    wait_beats(2, 100);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst_mid", {axis_out_tvalid, axis_out_tlast, axis_out_tdata}, 66'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    read_check("rst_len", 32'h04, 32'd64);
    read_check("rst_count", 32'h08, 32'd1);
    read_check("rst_dest", 32'h0C, 32'd0);
    read_check("rst_gap", 32'h10, 32'd0);
    read_check("rst_sent", 32'h14, 32'd0);
    read_check("rst_status", 32'h18, 32'd0);
    check("rst_no_beats", cap.size(), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_traffic_gen.md
AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

Interface
REQ-001 SHALL have parameter AXIS_BUS_WIDTH, default 64, stream data width in bits (multiple of 8, 32..512).
REQ-002 SHALL have parameter AXIS_DEST_WIDTH, default 4, tdest width.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, width of the packet byte-length register.
REQ-004 aclk  in  1  clock; all logic on its rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 axis_out_tdata/tdest/tkeep/tlast/tvalid  out  AXIS_BUS_WIDTH/AXIS_DEST_WIDTH/AXIS_BUS_WIDTH/8/1/1  generated packet stream.
REQ-007 axis_out_tready  in  1  downstream back-pressure.
REQ-008 ctrl_awaddr/ctrl_awvalid in 32/1; ctrl_awready out 1; write address channel.
REQ-009 ctrl_wdata/ctrl_wvalid in 32/1; ctrl_wready out 1; write data channel (no wstrb; full-word writes).
REQ-010 ctrl_bresp/ctrl_bvalid out 2/1; ctrl_bready in 1; write response.
REQ-011 ctrl_araddr/ctrl_arvalid in 32/1; ctrl_arready out 1; ctrl_rdata/ctrl_rresp/ctrl_rvalid out 32/2/1; ctrl_rready in 1; read channels.

Function
REQ-012 Register map (word offsets; addr[1:0] ignored): 0 CTRL (bit0 START write-1 pulse, bit1 STOP write-1 pulse), 1 LEN, 2 COUNT, 3 DEST, 4 GAP, 5 SENT, 6 STATUS (bit0 busy); other offsets read 0, writes ignored.
REQ-013 AXI-Lite write SHALL complete only when awvalid and wvalid are both high; awready and wready pulse high together for one cycle; bvalid rises next cycle with bresp=0 and holds until bready.
REQ-014 AXI-Lite read: arready pulses one cycle on arvalid; rvalid rises next cycle with rresp=0; rdata SHALL be held stable while rvalid is high and no new read is accepted until rvalid&rready.
REQ-015 FSM states IDLE, SEND, GAP; START in IDLE -> SEND next cycle, clearing SENT to 0 and latching LEN, COUNT, DEST, GAP into working copies.
REQ-016 Beats per packet = ceil(LEN/(AXIS_BUS_WIDTH/8)); LEN=0 SHALL be treated as 1.
REQ-017 Byte i of beat b SHALL equal (b*AXIS_BUS_WIDTH/8 + i) mod 256; beat counter restarts at 0 each packet.
REQ-018 tkeep all-ones except last beat: low (LEN mod BYTES) bits set, all-ones if remainder 0; tlast on last beat only; tdest = latched DEST.
REQ-019 tvalid SHALL stay high in SEND; tdata/tkeep/tlast/tdest stable while tvalid&~tready; beat advances only on tvalid&tready.
REQ-020 On last-beat handshake: SENT increments (wraps at 2^32); if COUNT!=0 and SENT+1==COUNT or STOP pending -> IDLE; else GAP if latched GAP>0, else SEND with no idle cycle.
REQ-021 GAP state SHALL hold tvalid low for exactly latched GAP cycles then return to SEND (or IDLE if STOP pending).
REQ-022 STOP SHALL never truncate a packet: sets a pending flag acted on at packet end or in GAP; STOP in IDLE has no effect.
REQ-023 START while busy SHALL be ignored; START and STOP in same write: STOP wins (no packets sent).
REQ-024 COUNT=0 means continuous until STOP.
REQ-025 Writes to LEN/DEST/GAP/COUNT while busy SHALL take effect only at the next START; SENT is read-only; busy=1 in SEND and GAP.

Reset
REQ-026 On aresetn low: state IDLE, tvalid=0, tlast=0, tdata/tkeep/tdest=0, all ready/valid AXI-Lite outputs 0, bresp/rresp/rdata=0, SENT=0, LEN=64, COUNT=1, DEST=0, GAP=0, STOP pending cleared.
REQ-027 Reset mid-packet SHALL drop tvalid on the next edge with no further beats; downstream must tolerate truncation.

Structure
REQ-028 Register offsets, CTRL bit indices and FSM state encoding SHALL live in a shared package traffic_gen_pkg.
REQ-029 AXI-Lite slave decode SHALL be a sub-module axil_reg_slave (write/read strobes, address, data) reusable by other apps; FSM and datapath in top.

Verification
REQ-030 LEN=64, COUNT=3, GAP=0, BUS 64, tready=1, START -> 24 beats back-to-back, tlast on beats 8/16/24, tkeep=0xFF, SENT reads 3, busy 0.
REQ-031 LEN=13, COUNT=1 -> 2 beats, beat0 bytes 0x00..0x07, beat1 bytes 0x08..0x0C, last tkeep=0x1F.
REQ-032 LEN=16, GAP=5, COUNT=2 -> exactly 5 tvalid-low cycles between packets.
REQ-033 tready toggled randomly, LEN=40 -> beats unchanged while stalled, pattern intact, no lost/dup beats.
REQ-034 COUNT=0, STOP mid-packet 3 -> packet 3 completes with tlast, then IDLE; SENT=3.
REQ-035 aresetn low during beat 2 of packet 1 -> tvalid 0 next cycle, all registers at reset values.
